// File: rtl/rs_multi_if.sv
// Bus bundle for rs_multi: decoder allocation, CDB wakeup, and the issue handshake.
// The RS uses the slave view; a decoder/ALU model uses the master view.
interface rs_multi_if #(
  parameter int IDX_W   = 3,
  parameter int ROB_W   = 4,
  parameter int NUM_CDB = 2,
  parameter int OP_W    = 5
);
  logic                     rdy_in;
  logic                     clear;
  logic                     dec_valid;
  logic [OP_W-1:0]          dec_op;
  logic [31:0]              dec_vj;
  logic [31:0]              dec_vk;
  logic                     dec_hj;
  logic                     dec_hk;
  logic [ROB_W-1:0]         dec_qj;
  logic [ROB_W-1:0]         dec_qk;
  logic [ROB_W-1:0]         dec_rob_id;
  logic [31:0]              dec_tja;
  logic [31:0]              dec_fja;
  logic                     rs_full;
  logic [IDX_W:0]           rs_count;
  logic [NUM_CDB-1:0]       cdb_valid;
  logic [NUM_CDB*ROB_W-1:0] cdb_rob_id;
  logic [NUM_CDB*32-1:0]    cdb_value;
  logic                     iss_valid;
  logic                     iss_ready;
  logic [OP_W-1:0]          iss_op;
  logic [31:0]              iss_vj;
  logic [31:0]              iss_vk;
  logic [ROB_W-1:0]         iss_rob_id;
  logic [31:0]              iss_tja;
  logic [31:0]              iss_fja;

  modport slave (
    input  rdy_in, clear, dec_valid, dec_op, dec_vj, dec_vk, dec_hj, dec_hk,
           dec_qj, dec_qk, dec_rob_id, dec_tja, dec_fja,
           cdb_valid, cdb_rob_id, cdb_value, iss_ready,
    output rs_full, rs_count, iss_valid, iss_op, iss_vj, iss_vk, iss_rob_id,
           iss_tja, iss_fja
  );

  modport master (
    output rdy_in, clear, dec_valid, dec_op, dec_vj, dec_vk, dec_hj, dec_hk,
           dec_qj, dec_qk, dec_rob_id, dec_tja, dec_fja,
           cdb_valid, cdb_rob_id, cdb_value, iss_ready,
    input  rs_full, rs_count, iss_valid, iss_op, iss_vj, iss_vk, iss_rob_id,
           iss_tja, iss_fja
  );
endinterface

// File: rtl/rs_multi.sv
// Reservation station with multi-channel CDB wakeup and oldest-ready-first issue.
// Age is kept as a matrix: r_older[i][j]=1 means entry i was allocated before entry j.
// A new entry clears its own row and sets its column, so stale bits from freed
// entries never affect ordering among valid entries and nothing wraps.
module rs_multi #(
  parameter int DEPTH   = 8,
  parameter int IDX_W   = 3,
  parameter int ROB_W   = 4,
  parameter int NUM_CDB = 2,
  parameter int OP_W    = 5
) (
  input logic      clk_in,
  input logic      rst_n_in,
  rs_multi_if.slave bus
);
  localparam logic [IDX_W:0] FULL_COUNT = (IDX_W+1)'(DEPTH);

  // Returns {hit, value}; scanning high to low lets the lowest channel win.
  function automatic logic [32:0] cdb_lookup(
    input logic [ROB_W-1:0]         tag,
    input logic [NUM_CDB-1:0]       vld,
    input logic [NUM_CDB*ROB_W-1:0] tags,
    input logic [NUM_CDB*32-1:0]    vals
  );
    logic [32:0] res;
    res = '0;
    for (int c = NUM_CDB - 1; c >= 0; c--) begin
      if (vld[c] && (tags[c*ROB_W +: ROB_W] == tag)) res = {1'b1, vals[c*32 +: 32]};
    end
    return res;
  endfunction

  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_hj;
  logic [DEPTH-1:0] r_hk;
  logic [OP_W-1:0]  r_op  [DEPTH];
  logic [31:0]      r_vj  [DEPTH];
  logic [31:0]      r_vk  [DEPTH];
  logic [ROB_W-1:0] r_qj  [DEPTH];
  logic [ROB_W-1:0] r_qk  [DEPTH];
  logic [ROB_W-1:0] r_rob [DEPTH];
  logic [31:0]      r_tja [DEPTH];
  logic [31:0]      r_fja [DEPTH];
  logic [DEPTH-1:0] r_older [DEPTH];
  logic [IDX_W:0]   r_count;

  logic [DEPTH-1:0] w_ready;
  logic [DEPTH-1:0] w_sel;
  logic [IDX_W-1:0] w_sel_idx;
  logic [IDX_W-1:0] w_free_idx;
  logic             w_free_found;
  logic             w_any_ready;
  logic             w_alloc;
  logic             w_issue;
  logic [32:0]      w_byp_j;
  logic [32:0]      w_byp_k;
  logic [32:0]      w_wake_j [DEPTH];
  logic [32:0]      w_wake_k [DEPTH];
  logic [OP_W-1:0]  w_iss_op;
  logic [31:0]      w_iss_vj;
  logic [31:0]      w_iss_vk;
  logic [ROB_W-1:0] w_iss_rob;
  logic [31:0]      w_iss_tja;
  logic [31:0]      w_iss_fja;

  assign w_ready     = r_valid & ~r_hj & ~r_hk;
  assign w_any_ready = |w_ready;
  assign w_alloc     = bus.dec_valid && !bus.rs_full && bus.rdy_in && !bus.clear;
  assign w_issue     = bus.iss_valid && bus.iss_ready && !bus.clear;

  assign bus.rs_full    = (r_count == FULL_COUNT);
  assign bus.rs_count   = r_count;
  assign bus.iss_valid  = w_any_ready && bus.rdy_in;
  assign bus.iss_op     = w_iss_op;
  assign bus.iss_vj     = w_iss_vj;
  assign bus.iss_vk     = w_iss_vk;
  assign bus.iss_rob_id = w_iss_rob;
  assign bus.iss_tja    = w_iss_tja;
  assign bus.iss_fja    = w_iss_fja;

  // Lowest-index free slot, from registered valid bits only.
  always_comb begin
    w_free_idx   = '0;
    w_free_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!r_valid[i] && !w_free_found) begin
        w_free_idx   = IDX_W'(i);
        w_free_found = 1'b1;
      end
    end
  end

  // CDB match for every stored operand and for the incoming decoder operands.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_wake_j[i] = cdb_lookup(r_qj[i], bus.cdb_valid, bus.cdb_rob_id, bus.cdb_value);
      w_wake_k[i] = cdb_lookup(r_qk[i], bus.cdb_valid, bus.cdb_rob_id, bus.cdb_value);
    end
    w_byp_j = cdb_lookup(bus.dec_qj, bus.cdb_valid, bus.cdb_rob_id, bus.cdb_value);
    w_byp_k = cdb_lookup(bus.dec_qk, bus.cdb_valid, bus.cdb_rob_id, bus.cdb_value);
  end

  // Oldest ready entry: ready with no older ready entry; drive its fields onto the issue port.
  always_comb begin
    w_sel     = '0;
    w_sel_idx = '0;
    w_iss_op  = '0;
    w_iss_vj  = '0;
    w_iss_vk  = '0;
    w_iss_rob = '0;
    w_iss_tja = '0;
    w_iss_fja = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_sel[i] = w_ready[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (w_ready[j] && r_older[j][i]) w_sel[i] = 1'b0;
      end
      if (w_sel[i]) begin
        w_sel_idx = IDX_W'(i);
        w_iss_op  = r_op[i];
        w_iss_vj  = r_vj[i];
        w_iss_vk  = r_vk[i];
        w_iss_rob = r_rob[i];
        w_iss_tja = r_tja[i];
        w_iss_fja = r_fja[i];
      end
    end
  end

  // Entry state: flush, wakeup, issue free, allocation with bypass, age and count.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_valid <= '0;
      r_hj    <= '0;
      r_hk    <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_op[i]    <= '0;
        r_vj[i]    <= '0;
        r_vk[i]    <= '0;
        r_qj[i]    <= '0;
        r_qk[i]    <= '0;
        r_rob[i]   <= '0;
        r_tja[i]   <= '0;
        r_fja[i]   <= '0;
        r_older[i] <= '0;
      end
    end else if (bus.rdy_in) begin
      if (bus.clear) begin
        r_valid <= '0;
        r_count <= '0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (r_valid[i] && r_hj[i] && w_wake_j[i][32]) begin
            r_vj[i] <= w_wake_j[i][31:0];
            r_hj[i] <= 1'b0;
          end
          if (r_valid[i] && r_hk[i] && w_wake_k[i][32]) begin
            r_vk[i] <= w_wake_k[i][31:0];
            r_hk[i] <= 1'b0;
          end
        end
        if (w_issue) r_valid[w_sel_idx] <= 1'b0;
        if (w_alloc) begin
          r_valid[w_free_idx] <= 1'b1;
          r_op[w_free_idx]    <= bus.dec_op;
          r_qj[w_free_idx]    <= bus.dec_qj;
          r_qk[w_free_idx]    <= bus.dec_qk;
          r_rob[w_free_idx]   <= bus.dec_rob_id;
          r_tja[w_free_idx]   <= bus.dec_tja;
          r_fja[w_free_idx]   <= bus.dec_fja;
          r_vj[w_free_idx]    <= (bus.dec_hj && w_byp_j[32]) ? w_byp_j[31:0] : bus.dec_vj;
          r_vk[w_free_idx]    <= (bus.dec_hk && w_byp_k[32]) ? w_byp_k[31:0] : bus.dec_vk;
          r_hj[w_free_idx]    <= bus.dec_hj && !w_byp_j[32];
          r_hk[w_free_idx]    <= bus.dec_hk && !w_byp_k[32];
          r_older[w_free_idx] <= '0;
          for (int j = 0; j < DEPTH; j++) begin
            if (IDX_W'(j) != w_free_idx) r_older[j][w_free_idx] <= 1'b1;
          end
        end
        r_count <= r_count + {{IDX_W{1'b0}}, w_alloc} - {{IDX_W{1'b0}}, w_issue};
      end
    end
  end
endmodule

// File: tb/tb_rs_multi.sv
// Directed bench for rs_multi: basic issue, oldest-first, full/drop, bypass, flush, async reset.
module tb_rs_multi;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  rs_multi_if #(.IDX_W(3), .ROB_W(4), .NUM_CDB(2), .OP_W(5)) bus ();

  rs_multi #(.DEPTH(8), .IDX_W(3), .ROB_W(4), .NUM_CDB(2), .OP_W(5)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dec(input logic v, input logic [4:0] op, input logic [31:0] vj,
                         input logic [31:0] vk, input logic hj, input logic [3:0] qj,
                         input logic [3:0] rob);
    bus.dec_valid  = v;
    bus.dec_op     = op;
    bus.dec_vj     = vj;
    bus.dec_vk     = vk;
    bus.dec_hj     = hj;
    bus.dec_qj     = qj;
    bus.dec_hk     = 1'b0;
    bus.dec_qk     = 4'd0;
    bus.dec_rob_id = rob;
    bus.dec_tja    = 32'h100 + {28'd0, rob};
    bus.dec_fja    = 32'h200 + {28'd0, rob};
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.rdy_in     = 1'b1;
    bus.clear      = 1'b0;
    bus.iss_ready  = 1'b0;
    bus.cdb_valid  = '0;
    bus.cdb_rob_id = '0;
    bus.cdb_value  = '0;
    set_dec(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 4'd0, 4'd0);
    repeat (3) tick();
    chk("rst_iss_valid", bus.iss_valid, 1'b0);
    chk("rst_count", bus.rs_count, 4'd0);
    chk("rst_full", bus.rs_full, 1'b0);
    chk("rst_iss_vj", bus.iss_vj, 32'd0);
    rst_n = 1'b1;
    tick();

    // basic issue
    bus.iss_ready = 1'b1;
    set_dec(1'b1, 5'h00, 32'd3, 32'd4, 1'b0, 4'd0, 4'd1);
    tick();
    bus.dec_valid = 1'b0;
    chk("basic_valid", bus.iss_valid, 1'b1);
    chk("basic_vj", bus.iss_vj, 32'd3);
    chk("basic_vk", bus.iss_vk, 32'd4);
    chk("basic_tja", bus.iss_tja, 32'h101);
    chk("basic_fja", bus.iss_fja, 32'h201);
    chk("basic_count1", bus.rs_count, 4'd1);
    tick();
    chk("basic_count0", bus.rs_count, 4'd0);
    chk("basic_empty", bus.iss_valid, 1'b0);

    // oldest first: A waits on tag 2, B and C ready
    bus.iss_ready = 1'b0;
    set_dec(1'b1, 5'd1, 32'd0, 32'd10, 1'b1, 4'd2, 4'd3);
    tick();
    set_dec(1'b1, 5'd2, 32'd20, 32'd21, 1'b0, 4'd0, 4'd4);
    tick();
    set_dec(1'b1, 5'd3, 32'd30, 32'd31, 1'b0, 4'd0, 4'd5);
    tick();
    bus.dec_valid = 1'b0;
    chk("age_count3", bus.rs_count, 4'd3);
    chk("age_pres_B", bus.iss_rob_id, 4'd4);
    bus.cdb_valid  = 2'b10;
    bus.cdb_rob_id = {4'd2, 4'd0};
    bus.cdb_value  = {32'd9, 32'd0};
    tick();
    bus.cdb_valid = '0;
    chk("age_pres_A", bus.iss_rob_id, 4'd3);
    chk("age_A_vj", bus.iss_vj, 32'd9);
    chk("age_A_op", bus.iss_op, 5'd1);
    bus.iss_ready = 1'b1;
    tick();
    chk("age_then_B", bus.iss_rob_id, 4'd4);
    tick();
    chk("age_then_C", bus.iss_rob_id, 4'd5);
    tick();
    chk("age_drained", bus.iss_valid, 1'b0);
    chk("age_count0", bus.rs_count, 4'd0);

    // fill with dependent ops, entry i waits on tag i+8
    for (int i = 0; i < 8; i++) begin
      set_dec(1'b1, 5'd4, 32'd0, 32'd0, 1'b1, 4'(i + 8), 4'(i));
      tick();
    end
    set_dec(1'b1, 5'd5, 32'd1, 32'd1, 1'b0, 4'd0, 4'd15);
    chk("fill_full", bus.rs_full, 1'b1);
    chk("fill_count8", bus.rs_count, 4'd8);
    tick();
    chk("drop_count8", bus.rs_count, 4'd8);
    chk("drop_no_issue", bus.iss_valid, 1'b0);
    bus.dec_valid  = 1'b0;
    bus.iss_ready  = 1'b0;
    bus.cdb_valid  = 2'b01;
    bus.cdb_rob_id = {4'd0, 4'd11};
    bus.cdb_value  = {32'd0, 32'h33};
    tick();
    bus.cdb_valid = '0;
    chk("wake3_valid", bus.iss_valid, 1'b1);
    chk("wake3_rob", bus.iss_rob_id, 4'd3);
    chk("wake3_vj", bus.iss_vj, 32'h33);
    bus.iss_ready = 1'b1;
    set_dec(1'b1, 5'd6, 32'h44, 32'd0, 1'b0, 4'd0, 4'd14);
    tick();
    bus.iss_ready = 1'b0;
    chk("simul_count7", bus.rs_count, 4'd7);
    chk("simul_not_full", bus.rs_full, 1'b0);
    chk("simul_alloc_blocked", bus.iss_valid, 1'b0);
    tick();
    bus.dec_valid = 1'b0;
    chk("realloc_count8", bus.rs_count, 4'd8);
    chk("realloc_full", bus.rs_full, 1'b1);
    chk("realloc_rob", bus.iss_rob_id, 4'd14);
    chk("realloc_vj", bus.iss_vj, 32'h44);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    chk("drain_clear", bus.rs_count, 4'd0);

    // bypass with both channels matching: channel 0 wins
    set_dec(1'b1, 5'd7, 32'd0, 32'd7, 1'b1, 4'd6, 4'd6);
    bus.cdb_valid  = 2'b11;
    bus.cdb_rob_id = {4'd6, 4'd6};
    bus.cdb_value  = {32'h22, 32'h11};
    tick();
    bus.dec_valid = 1'b0;
    bus.cdb_valid = '0;
    chk("byp_valid", bus.iss_valid, 1'b1);
    chk("byp_vj", bus.iss_vj, 32'h11);
    chk("byp_rob", bus.iss_rob_id, 4'd6);
    bus.iss_ready = 1'b1;
    tick();
    bus.iss_ready = 1'b0;
    chk("byp_count0", bus.rs_count, 4'd0);

    // flush with same-cycle allocation
    for (int i = 1; i <= 5; i++) begin
      set_dec(1'b1, 5'd8, 32'(i), 32'd0, 1'b0, 4'd0, 4'(i));
      tick();
    end
    bus.dec_valid = 1'b0;
    chk("fl_count5", bus.rs_count, 4'd5);
    chk("fl_oldest", bus.iss_rob_id, 4'd1);
    bus.clear     = 1'b1;
    bus.dec_valid = 1'b1;
    tick();
    bus.clear     = 1'b0;
    bus.dec_valid = 1'b0;
    chk("fl_count0", bus.rs_count, 4'd0);
    chk("fl_no_issue", bus.iss_valid, 1'b0);

    // clear held off by stall
    set_dec(1'b1, 5'd9, 32'd70, 32'd0, 1'b0, 4'd0, 4'd7);
    tick();
    set_dec(1'b1, 5'd9, 32'd80, 32'd0, 1'b0, 4'd0, 4'd8);
    tick();
    bus.dec_valid = 1'b0;
    chk("stall_pre_count", bus.rs_count, 4'd2);
    bus.clear  = 1'b1;
    bus.rdy_in = 1'b0;
    #1;
    chk("stall_iss_forced0", bus.iss_valid, 1'b0);
    tick();
    chk("stall_count_held", bus.rs_count, 4'd2);
    bus.rdy_in = 1'b1;
    #1;
    chk("stall_release_valid", bus.iss_valid, 1'b1);
    tick();
    bus.clear = 1'b0;
    chk("stall_clear_count", bus.rs_count, 4'd0);
    chk("stall_clear_valid", bus.iss_valid, 1'b0);

    // asynchronous reset between edges
    set_dec(1'b1, 5'd10, 32'd5, 32'd6, 1'b0, 4'd0, 4'd9);
    tick();
    bus.dec_valid = 1'b0;
    chk("ar_pre_valid", bus.iss_valid, 1'b1);
    chk("ar_pre_count", bus.rs_count, 4'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_iss_valid", bus.iss_valid, 1'b0);
    chk("ar_count", bus.rs_count, 4'd0);
    chk("ar_iss_vj", bus.iss_vj, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/rs_multi.md
Name: rs_multi

Overview:
- Parametrised reservation station that succeeds the single-broadcast, lowest-index-issue RS.
- Holds up to DEPTH decoded ALU/branch ops and wakes operands from NUM_CDB result broadcast channels.
- Issues the oldest ready entry to an external execution unit over a valid/ready handshake.
- Sits between the decoder and the ALU; the ROB clear flushes it.

Parameters:
- DEPTH, 8: number of entries; must be at least 2 and a power of two.
- IDX_W, 3: log2(DEPTH).
- ROB_W, 4: ROB tag width.
- NUM_CDB, 2: number of wakeup broadcast channels.
- OP_W, 5: op/type field width.

Ports:
- clk_in  in  1  system clock
- rst_n_in  in  1  asynchronous active-low reset
- rdy_in  in  1  global stall; state frozen when low
- clear  in  1  flush (mispredict), qualified by rdy_in
- dec_valid  in  1  decoder presents op this cycle
- dec_op  in  OP_W  op type
- dec_vj / dec_vk  in  32 each  operand values
- dec_hj / dec_hk  in  1 each  operand j/k still pending
- dec_qj / dec_qk  in  ROB_W each  producer tags
- dec_rob_id  in  ROB_W  destination tag
- dec_tja / dec_fja  in  32 each  taken / not-taken addresses
- rs_full  out  1  no free entry
- rs_count  out  IDX_W+1  occupied entries
- cdb_valid  in  NUM_CDB  per-channel broadcast valid
- cdb_rob_id  in  NUM_CDB*ROB_W  packed tags; channel c at [c*ROB_W +: ROB_W]
- cdb_value  in  NUM_CDB*32  packed values
- iss_valid  out  1  issue op valid
- iss_ready  in  1  execution unit accepts
- iss_op, iss_vj, iss_vk, iss_rob_id, iss_tja, iss_fja  out  issued entry fields

Behaviour:
- Reset (rst_n_in low, asynchronous):
  - All entries invalid; age order cleared.
  - rs_full=0, rs_count=0, iss_valid=0, all iss_* data=0.
- Stall: all state holds while rdy_in=0, and iss_valid is forced to 0 so no handshake completes.
- Clear (clear && rdy_in at an edge):
  - All entries are invalidated. rs_count=0 and iss_valid=0 from the next cycle.
  - Clear takes priority over a same-cycle allocation, wakeup or issue. The issue in that cycle counts as not accepted.
- Allocation (dec_valid && !rs_full && rdy_in && !clear):
  - Writes the lowest-index free entry.
  - rs_full and rs_count are registered and reflect the state at the start of the cycle. dec_valid while rs_full is ignored and the op is dropped; the decoder must not do this.
  - A slot freed by an issue in the same cycle is not reusable until the next cycle.
- Allocation bypass: for each operand with dec_h*=1, if any cdb_valid[c] carries a matching tag that cycle, the value is captured and the pending flag is cleared at write. With multiple matches, the lowest-numbered channel wins.
- Wakeup: every valid entry with a pending operand whose tag matches a valid CDB channel captures the value and clears its pending flag at the edge. The same lowest-channel-wins rule applies.
- Ready definition: entry valid with both pending flags clear (registered state only). An entry woken at edge T is issue-eligible in the cycle after T, not the same cycle.
- Selection: iss_valid=1 iff some entry is ready. iss_* present the oldest ready entry, where age means allocation order. Selection is combinational from registered state.
- Issue handshake:
  - When iss_valid && iss_ready at an edge, the selected entry is freed.
  - When iss_ready=0, the same oldest-ready entry stays presented until accepted, unless an older entry becomes ready first. In that case the older entry is presented instead; no ordering is promised to the consumer beyond oldest-first.
- Occupancy count:
  - rs_count' = rs_count + alloc − issue. Simultaneous alloc and issue leave the count unchanged.
  - rs_full = (rs_count == DEPTH).
  - rs_count never exceeds DEPTH and never underflows.
- Age tracking survives arbitrary interleaving with no wrap-around artefacts. An age matrix or equivalent is acceptable.
- Tag 0 is a legal tag; matching is gated only by the pending flag and cdb_valid.

Test Plan:
- Reset and basic issue: reset low for 3 cycles, then allocate op=5'h00, vj=3, vk=4, no deps, with iss_ready=1. Required: iss_valid rises the cycle after allocation with iss_vj=3, iss_vk=4, and rs_count returns to 0.
- Oldest-first: allocate A (dep qj=2), then B (ready), then C (ready), with iss_ready=0. Required: B is presented. Broadcast tag 2 on cdb channel 1 with value 9. Required: from the next cycle A is presented with iss_vj=9, and accept order is A, B, C.
- Fill, then simultaneous events: fill 8 entries, all with dependencies. Required: rs_full=1, and dec_valid is dropped with count held at 8. Wake one entry, then issue it alongside dec_valid. Required: the allocation is blocked that cycle, count goes to 7, and an allocation the next cycle succeeds with count back to 8.
- Bypass, dual channel: allocate with dec_hj=1, qj=6, while cdb0 and cdb1 both carry tag 6 with values 0x11 and 0x22. Required: the entry captures vj=0x11 and issues the next cycle.
- Flush: with 5 entries held and iss_ready=0, assert clear together with dec_valid. Required: rs_count=0 and iss_valid=0 next cycle, with no allocation. Pulse rdy_in low with clear high. Required: no flush until rdy_in is high.
- Async reset mid-operation: drop rst_n_in between clock edges while iss_valid=1. Required: iss_valid=0 and rs_count=0 immediately, without waiting for an edge.
